// File: rtl/disp_stream_arbiter.sv
// -----------------------------------------------------------------------------
// disp_stream_arbiter
//
// Purpose:
//   Merges two disparity streams (source 0 = left, source 1 = right) onto one
//   output stream. Ownership of the output is granted for one complete
//   decimated row at a time. Every row is followed by a single IDLE
//   arbitration cycle. Word payloads pass combinationally from the granted
//   source to the output, so there is no added latency inside a row.
//
// Parameters:
//   disp_bits        disparity field width of each input word
//   dec_frame_width  words per decimated row
//   dec_frame_height rows per decimated frame
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   in0_data   source 0 word {disp, conf}   (disp_bits+8 bits)
//   in0_valid  source 0 word available
//   in0_ready  source 0 word accepted this cycle
//   in1_*      same as in0_* for source 1
//   out_data   {src_id, granted source word} (disp_bits+9 bits)
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   out_sof    word is row 0, column 0 of its source frame
//   out_eol    word is the last column of a row
//
// Configuration:
//   DISP_ARB_STRICT_ALT_EN  when defined, IDLE grants only the source that
//                           did not own the previous row. It waits for that
//                           source even if the other source is valid. When
//                           the macro is undefined, arbitration is
//                           work-conserving round-robin.
// -----------------------------------------------------------------------------
module disp_stream_arbiter #(
  parameter int disp_bits        = 5,
  parameter int dec_frame_width  = 240,
  parameter int dec_frame_height = 180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [disp_bits+7:0] in0_data,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [disp_bits+7:0] in1_data,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  output logic [disp_bits+8:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol
);

  localparam int COL_W = (dec_frame_width  > 1) ? $clog2(dec_frame_width)  : 1;
  localparam int ROW_W = (dec_frame_height > 1) ? $clog2(dec_frame_height) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(dec_frame_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(dec_frame_height - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row0_q;
  logic [ROW_W-1:0]   row1_q;
  logic               last_grant_q;

  logic               sel;
  logic               granted;
  logic               grant_vld;
  logic               col_last;
  logic               row_zero;
  logic               beat;

  // Output decode from the registered grant. Reset is also used here to gate
  // the outputs. This blanks them combinationally while reset is high,
  // including the first reset cycle, before the state register has returned
  // to IDLE.
  always_comb begin
    sel       = (state_q == GRANT1);
    granted   = (state_q != IDLE) && !reset;
    grant_vld = sel ? in1_valid : in0_valid;
    col_last  = (col_q == COL_LAST);
    row_zero  = sel ? (row1_q == '0) : (row0_q == '0);

    out_valid = granted && grant_vld;
    in0_ready = granted && !sel && out_ready;
    in1_ready = granted &&  sel && out_ready;
    out_data  = sel ? {1'b1, in1_data} : {1'b0, in0_data};
    out_eol   = granted && col_last;
    out_sof   = granted && row_zero && (col_q == '0);

    beat      = out_valid && out_ready;
  end

  // Row-granular arbitration FSM. The column counter advances only on an
  // accepted beat, so mid-row stalls hold all state. The grant is released
  // only after the last column of a row has been accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row0_q       <= '0;
      row1_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef DISP_ARB_STRICT_ALT_EN
          // Strict alternation: only the source that did not own the
          // previous row may be granted.
          if (last_grant_q) begin
            if (in0_valid) state_q <= GRANT0;
          end else begin
            if (in1_valid) state_q <= GRANT1;
          end
`else
          // Work-conserving round-robin: a tie goes to the source that did
          // not own the previous row.
          if (in0_valid && in1_valid) begin
            state_q <= last_grant_q ? GRANT0 : GRANT1;
          end else if (in0_valid) begin
            state_q <= GRANT0;
          end else if (in1_valid) begin
            state_q <= GRANT1;
          end
`endif
        end

        GRANT0, GRANT1: begin
          if (beat) begin
            if (col_last) begin
              col_q        <= '0;
              last_grant_q <= sel;
              state_q      <= IDLE;
              if (sel) begin
                row1_q <= (row1_q == ROW_LAST) ? '0 : row1_q + 1'b1;
              end else begin
                row0_q <= (row0_q == ROW_LAST) ? '0 : row0_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_stream_arbiter.sv
module tb_disp_stream_arbiter;

  localparam int DB = 5;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = DB + 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in0_data = '0;
  logic          in0_valid = 1'b0;
  logic          in0_ready;
  logic [DW-1:0] in1_data = '0;
  logic          in1_valid = 1'b0;
  logic          in1_ready;
  logic [DW:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic          out_eol;

  disp_stream_arbiter #(
    .disp_bits       (DB),
    .dec_frame_width (W),
    .dec_frame_height(H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in0_data (in0_data),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in1_data (in1_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  typedef struct { logic [DW:0] data; logic sof; logic eol; } beat_t;
  typedef struct { logic ov; logic r0; logic r1; } ctl_t;

  beat_t bq[$];
  ctl_t  cq[$];
  int    row_src[$];
  int    row_sof[$];

  // Payload for the s-th word of source n; the same function drives the
  // sources and forms the expectation, so any lost or repeated word shifts
  // the sequence and shows up as a data difference.
  function automatic logic [DW-1:0] word(input int n, input int s);
    return DW'(s * 37 + n * 2741 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: row-level ownership bookkeeping evaluated once per cycle
  // on the falling edge, from the rules of the arbitration scheme.
  int m_own = -1;
  int m_col = 0;
  int m_last = 1;
  int m_row[2] = '{0, 0};
  int m_seq[2] = '{0, 0};

  initial forever begin
    logic v;
    @(negedge clk);
    if (reset) begin
      cq.push_back('{1'b0, 1'b0, 1'b0});
      m_own = -1; m_col = 0; m_last = 1; m_row = '{0, 0};
    end else if (m_own < 0) begin
      cq.push_back('{1'b0, 1'b0, 1'b0});
`ifdef DISP_ARB_STRICT_ALT_EN
      if (m_last == 1 && in0_valid) m_own = 0;
      else if (m_last == 0 && in1_valid) m_own = 1;
`else
      if (in0_valid && in1_valid) m_own = 1 - m_last;
      else if (in0_valid) m_own = 0;
      else if (in1_valid) m_own = 1;
`endif
    end else begin
      v = (m_own == 1) ? in1_valid : in0_valid;
      cq.push_back('{v, (m_own == 0) && out_ready, (m_own == 1) && out_ready});
      if (v && out_ready) begin
        bq.push_back('{{m_own[0], word(m_own, m_seq[m_own])},
                       (m_row[m_own] == 0) && (m_col == 0), (m_col == W - 1)});
        m_seq[m_own]++;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row[m_own] = (m_row[m_own] + 1) % H;
          m_last = m_own;
          m_own = -1;
        end
      end
    end
  end

  // Monitor: compares the handshake each cycle and pops a beat whenever the
  // DUT transfers one.
  initial forever begin
    ctl_t  c;
    beat_t b;
    bit    first;
    @(negedge clk); #1;
    if (cq.size() == 0) begin
      check("ctl_queue_empty", 32'd0, 32'd1);
    end else begin
      c = cq.pop_front();
      check("handshake", {29'd0, out_valid, in0_ready, in1_ready}, {29'd0, c.ov, c.r0, c.r1});
    end
    check("ready_exclusive", {31'd0, in0_ready && in1_ready}, 32'd0);
    if (reset) first = 1'b1;
    if (out_valid && out_ready) begin
      beats++;
      if (bq.size() == 0) begin
        check("unexpected_beat", {18'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        b = bq.pop_front();
        check("beat", {16'd0, out_data, out_sof, out_eol}, {16'd0, b.data, b.sof, b.eol});
      end
      if (first) row_sof.push_back(int'(out_sof));
      first = out_eol;
      if (out_eol) row_src.push_back(int'(out_data[DW]));
    end
  end

  // Stimulus driver: sources advance their word only on an observed accept.
  int  d_seq[2] = '{0, 0};
  bit  last_a1 = 1'b0;

  task automatic step(input bit r, input bit v0, input bit v1, input bit ordy);
    bit a0, a1;
    @(negedge clk);
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    last_a1 = a1;
    @(posedge clk); #1;
    if (a0) d_seq[0]++;
    if (a1) d_seq[1]++;
    reset     = r;
    in0_valid = v0;
    in1_valid = v1;
    out_ready = ordy;
    in0_data  = word(0, d_seq[0]);
    in1_data  = word(1, d_seq[1]);
  endtask

  initial begin
    int k;
    in0_data = word(0, 0);
    in1_data = word(1, 0);

    repeat (3) step(1, 0, 0, 1);
    row_src.delete(); row_sof.delete();

    // Both sources always valid: rows alternate 0,1,0,1 and sof reappears on row H.
    repeat (45) step(0, 1, 1, 1);
    check("alt_rows_count", {31'd0, row_src.size() >= 6}, 32'd1);
    if (row_src.size() >= 6) begin
      check("alt_row0_src", row_src[0], 0);
      check("alt_row1_src", row_src[1], 1);
      check("alt_row2_src", row_src[2], 0);
      check("alt_row3_src", row_src[3], 1);
      check("alt_sof_pattern", {26'd0, row_sof[0][0], row_sof[1][0], row_sof[2][0],
                                row_sof[3][0], row_sof[4][0], row_sof[5][0]}, 32'b110011);
    end

    // Only source 1 valid.
    repeat (2) step(1, 0, 0, 1);
    row_src.delete(); row_sof.delete();
    repeat (40) step(0, 0, 1, 1);
`ifndef DISP_ARB_STRICT_ALT_EN
    check("src1_rows_count", {31'd0, row_src.size() >= 4}, 32'd1);
    k = 0;
    foreach (row_src[i]) if (row_src[i] != 1) k++;
    check("src1_rows_all_src1", k, 0);
    if (row_sof.size() >= 3)
      check("src1_sof_wrap", {29'd0, row_sof[0][0], row_sof[1][0], row_sof[2][0]}, 32'b101);
`endif

    // Randomised valids with ~50% downstream backpressure.
    repeat (500) step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    // Reset in the middle of a source-1 row (column 2 presented).
    repeat (2) step(1, 0, 0, 1);
    k = 0;
    for (int i = 0; i < 60 && k < 2; i++) begin
      step(0, 1, 1, 1);
      if (last_a1) k++;
    end
    check("mid_row_reach_col2", k, 2);
    check("mid_row_col2_presented", {29'd0, out_valid, in1_ready, out_data[DW]}, 32'b111);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    row_src.delete(); row_sof.delete();
    repeat (8) step(0, 1, 1, 1);
    check("post_reset_row_seen", {31'd0, row_src.size() >= 1}, 32'd1);
    if (row_src.size() >= 1) begin
      check("post_reset_src0", row_src[0], 0);
      check("post_reset_sof", row_sof[0], 1);
    end

    // Randomised traffic, mostly ready.
    repeat (300) step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);

    repeat (4) step(0, 0, 0, 1);
    check("beat_queue_drained", bq.size(), 0);
    check("enough_beats", {31'd0, beats > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
